// File: rtl/mem_resp_stage_pkg.sv
// mem_resp_stage shared definitions.
// Load opcodes, exception code width, ALE code and the MS field bundle.
package mem_resp_stage_pkg;

  localparam int EXCP_NUM_W = 16;
  localparam logic [EXCP_NUM_W-1:0] EXCP_ALE = 16'h0009;

  typedef enum logic [2:0] {
    LD_NONE = 3'b000,
    LD_B    = 3'b001,
    LD_BU   = 3'b010,
    LD_H    = 3'b011,
    LD_HU   = 3'b100,
    LD_W    = 3'b101,
    LD_WU   = 3'b110,
    LD_D    = 3'b111
  } ld_op_e;

  typedef struct packed {
    logic [31:0]           pc;
    ld_op_e                ld_op;
    logic                  req_sent;
    logic [4:0]            dest;
    logic                  gr_we;
    logic                  excp;
    logic [EXCP_NUM_W-1:0] excp_num;
  } ms_info_t;

endpackage

// File: rtl/mem_resp_stage_if.sv
// EX/SRAM/WB facing signal bundle of the memory-response stage.
// slave is the stage's view, master the surrounding pipeline's view.
interface mem_resp_stage_if #(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
);
  import mem_resp_stage_pkg::*;

  logic                  es_to_ms_valid;
  logic                  ms_allowin;
  logic                  es_req_fire;
  logic                  es_req_sent;
  logic [2:0]            es_ld_op;
  logic [OFF_W-1:0]      es_addr_low;
  logic [31:0]           es_pc;
  logic [DATA_W-1:0]     es_result;
  logic [4:0]            es_dest;
  logic                  es_gr_we;
  logic                  es_excp;
  logic [EXCP_NUM_W-1:0] es_excp_num;
  logic                  data_sram_data_ok;
  logic [DATA_W-1:0]     data_sram_rdata;
  logic                  ms_req_full;
  logic                  ms_ld_wait;
  logic                  ws_allowin;
  logic                  ms_to_ws_valid;
  logic [31:0]           ms_pc;
  logic [DATA_W-1:0]     ms_final_result;
  logic [4:0]            ms_dest;
  logic                  ms_gr_we;
  logic                  ms_excp;
  logic [EXCP_NUM_W-1:0] ms_excp_num;
  logic                  flush;

  modport slave (
    input  es_to_ms_valid, es_req_fire, es_req_sent,
    input  es_ld_op, es_addr_low, es_pc, es_result,
    input  es_dest, es_gr_we, es_excp, es_excp_num,
    input  data_sram_data_ok, data_sram_rdata,
    input  ws_allowin, flush,
    output ms_allowin, ms_req_full, ms_ld_wait,
    output ms_to_ws_valid, ms_pc, ms_final_result,
    output ms_dest, ms_gr_we, ms_excp, ms_excp_num
  );

  modport master (
    output es_to_ms_valid, es_req_fire, es_req_sent,
    output es_ld_op, es_addr_low, es_pc, es_result,
    output es_dest, es_gr_we, es_excp, es_excp_num,
    output data_sram_data_ok, data_sram_rdata,
    output ws_allowin, flush,
    input  ms_allowin, ms_req_full, ms_ld_wait,
    input  ms_to_ws_valid, ms_pc, ms_final_result,
    input  ms_dest, ms_gr_we, ms_excp, ms_excp_num
  );

endinterface

// File: rtl/mem_ld_extract.sv
// Load lane select and sign/zero extension.
// Byte offset shifts the addressed lane down to bit 0.
module mem_ld_extract
  import mem_resp_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] data,
  input  ld_op_e            ld_op,
  input  logic [OFF_W-1:0]  off,
  output logic [DATA_W-1:0] res
);

  logic [DATA_W-1:0] lane;

  assign lane = data >> {off, 3'b000};

  always_comb begin
    res = lane;
    unique case (1'b1)
      ld_op == LD_B:  res = DATA_W'($signed(lane[7:0]));
      ld_op == LD_BU: res = DATA_W'(lane[7:0]);
      ld_op == LD_H:  res = DATA_W'($signed(lane[15:0]));
      ld_op == LD_HU: res = DATA_W'(lane[15:0]);
      ld_op == LD_W:  res = DATA_W'($signed(lane[31:0]));
      ld_op == LD_WU: res = DATA_W'(lane[31:0]);
      default:        res = lane;
    endcase
  end

endmodule

// File: rtl/mem_resp_stage.sv
// MS stage: tracks data requests, waits for load data, drops cancelled responses.
// Define MS_ALE_CHECK_EN to raise ALE on misaligned h/hu/w/wu loads.
module mem_resp_stage
  import mem_resp_stage_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int OFF_W           = $clog2(DATA_W / 8),
  parameter int MAX_OUTSTANDING = 2,
  parameter int CNT_W           = 3
) (
  input logic             clk,
  input logic             reset,
  mem_resp_stage_if.slave bus
);

  ms_info_t          info;
  logic              ms_valid;
  logic [OFF_W-1:0]  addr_low;
  logic [DATA_W-1:0] result;
  logic [DATA_W-1:0] buf_data;
  logic              buf_vld;
  logic [CNT_W-1:0]  outst_cnt;
  logic [CNT_W-1:0]  cancel_cnt;
  logic [CNT_W-1:0]  outst_next;
  logic [DATA_W-1:0] ld_data;
  logic              is_ld;
  logic              waiting;
  logic              ready_go;
  logic              handoff;
  logic              capture;
  logic              drop;
  logic              fill;
  logic              ale;

  assign is_ld    = ms_valid & (info.ld_op != LD_NONE);
  assign waiting  = is_ld & info.req_sent & ~buf_vld;
  assign ready_go = ~waiting | info.excp;
  assign handoff  = ms_valid & ready_go & bus.ws_allowin;
  assign capture  = bus.es_to_ms_valid & bus.ms_allowin
                  & ~bus.flush;
  assign drop     = bus.data_sram_data_ok & (cancel_cnt != '0);
  assign fill     = bus.data_sram_data_ok & ~drop
                  & waiting & ~bus.flush;

  assign outst_next = outst_cnt
                    + CNT_W'(bus.es_req_fire)
                    - CNT_W'(bus.data_sram_data_ok);

`ifdef MS_ALE_CHECK_EN
  always_comb begin
    ale = 1'b0;
    unique case (1'b1)
      ld_op_e'(bus.es_ld_op) == LD_H,
      ld_op_e'(bus.es_ld_op) == LD_HU:
        ale = bus.es_addr_low[0];
      ld_op_e'(bus.es_ld_op) == LD_W,
      ld_op_e'(bus.es_ld_op) == LD_WU:
        ale = |bus.es_addr_low[1:0];
      default:
        ale = 1'b0;
    endcase
  end
`else
  assign ale = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (bus.flush) begin
      ms_valid <= 1'b0;
    end else if (bus.ms_allowin) begin
      ms_valid <= bus.es_to_ms_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      info     <= '0;
      addr_low <= '0;
      result   <= '0;
    end else if (capture) begin
      info.pc       <= bus.es_pc;
      info.ld_op    <= ld_op_e'(bus.es_ld_op);
      info.req_sent <= bus.es_req_sent;
      info.dest     <= bus.es_dest;
      info.gr_we    <= bus.es_gr_we;
      info.excp     <= bus.es_excp | ale;
      info.excp_num <= (ale & ~bus.es_excp) ? EXCP_ALE
                                            : bus.es_excp_num;
      addr_low      <= bus.es_addr_low;
      result        <= bus.es_result;
    end
  end

  // Every request still outstanding after a flush belongs to a killed op.
  always_ff @(posedge clk) begin
    if (reset) begin
      outst_cnt  <= '0;
      cancel_cnt <= '0;
    end else begin
      outst_cnt <= outst_next;
      if (bus.flush) begin
        cancel_cnt <= outst_next;
      end else if (drop) begin
        cancel_cnt <= cancel_cnt - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_vld  <= 1'b0;
      buf_data <= '0;
    end else begin
      if (fill) begin
        buf_data <= bus.data_sram_rdata;
      end
      if (bus.flush) begin
        buf_vld <= 1'b0;
      end else if (fill) begin
        buf_vld <= 1'b1;
      end else if (handoff) begin
        buf_vld <= 1'b0;
      end
    end
  end

  mem_ld_extract #(
    .DATA_W(DATA_W),
    .OFF_W (OFF_W)
  ) u_extract (
    .data (buf_data),
    .ld_op(info.ld_op),
    .off  (addr_low),
    .res  (ld_data)
  );

  assign bus.ms_allowin      = ~reset
                             & (~ms_valid | (ready_go & bus.ws_allowin));
  assign bus.ms_to_ws_valid  = ms_valid & ready_go;
  assign bus.ms_req_full     = outst_cnt == CNT_W'(MAX_OUTSTANDING);
  assign bus.ms_ld_wait      = is_ld & ~ready_go;
  assign bus.ms_pc           = info.pc;
  assign bus.ms_final_result = (info.ld_op != LD_NONE) ? ld_data
                                                       : result;
  assign bus.ms_dest         = info.dest;
  assign bus.ms_gr_we        = info.gr_we;
  assign bus.ms_excp         = info.excp;
  assign bus.ms_excp_num     = info.excp_num;

  a_fire_full: assert property (
    @(posedge clk) disable iff (reset)
    !(bus.es_req_fire && bus.ms_req_full));

  a_orphan_rsp: assert property (
    @(posedge clk) disable iff (reset)
    !(bus.data_sram_data_ok && cancel_cnt == '0
      && !waiting && !bus.flush));

endmodule

// File: tb/tb_mem_resp_stage.sv
// Directed and randomized checks of mem_resp_stage (DATA_W=32).
// Random phase compares hand-offs against a queue-based load model.
module tb_mem_resp_stage;
  import mem_resp_stage_pkg::*;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] res;
    logic [4:0]  dest;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  mem_resp_stage_if #(.DATA_W(32)) bus ();

  mem_resp_stage #(.DATA_W(32)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic idle();
    bus.es_to_ms_valid    = 1'b0;
    bus.es_req_fire       = 1'b0;
    bus.es_req_sent       = 1'b0;
    bus.es_ld_op          = 3'b000;
    bus.es_addr_low       = 2'b00;
    bus.es_pc             = 32'h0;
    bus.es_result         = 32'h0;
    bus.es_dest           = 5'd0;
    bus.es_gr_we          = 1'b0;
    bus.es_excp           = 1'b0;
    bus.es_excp_num       = 16'h0;
    bus.data_sram_data_ok = 1'b0;
    bus.data_sram_rdata   = 32'h0;
    bus.ws_allowin        = 1'b1;
    bus.flush             = 1'b0;
  endtask

  // Reference extraction from the load rules, in plain arithmetic.
  function automatic logic [31:0] ref_ld(input logic [2:0] op,
                                         input int off,
                                         input logic [31:0] d);
    longint v;
    longint r;
    v = longint'(d) / (longint'(1) << (8 * off));
    r = v;
    case (op)
      3'b001: r = (v % 256 >= 128) ? v % 256 - 256 : v % 256;
      3'b010: r = v % 256;
      3'b011: r = (v % 65536 >= 32768) ? v % 65536 - 65536 : v % 65536;
      3'b100: r = v % 65536;
      default: r = v;
    endcase
    return 32'(r);
  endfunction

  task automatic issue(input logic [2:0] op, input logic [1:0] off,
                       input logic [31:0] pc, input logic [31:0] res);
    bus.es_to_ms_valid = 1'b1;
    bus.es_ld_op       = op;
    bus.es_addr_low    = off;
    bus.es_pc          = pc;
    bus.es_result      = res;
    bus.es_dest        = pc[6:2];
    bus.es_gr_we       = 1'b1;
    bus.es_req_fire    = op != 3'b000;
    bus.es_req_sent    = op != 3'b000;
    sample();
    chk("issue_allowin", 64'(bus.ms_allowin), 64'd1);
    step();
    bus.es_to_ms_valid = 1'b0;
    bus.es_req_fire    = 1'b0;
    bus.es_req_sent    = 1'b0;
  endtask

  task automatic respond(input logic [31:0] d);
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = d;
    step();
    bus.data_sram_data_ok = 1'b0;
  endtask

  task automatic run_load(input string tag, input logic [2:0] op,
                          input logic [1:0] off, input logic [31:0] d,
                          input logic [31:0] exp);
    issue(op, off, 32'h1c00_0100 + 32'(off), 32'h0);
    respond(d);
    sample();
    chk({tag, "_valid"}, 64'(bus.ms_to_ws_valid), 64'd1);
    chk({tag, "_result"}, 64'(bus.ms_final_result), 64'(exp));
    step();
  endtask

  exp_t        exp_q[$];
  int          mem_due[$];
  logic [31:0] mem_dat[$];

  initial begin
    int          waits;
    int          last_due;
    int          handoffs;
    bit          ex_pending;
    bit          flushing;
    bit          take;
    bit          ex_ld;
    logic [2:0]  ex_op;
    logic [1:0]  ex_off;
    logic [31:0] ex_pc;
    logic [31:0] ex_res;
    logic [31:0] d;
    exp_t        e;
    int          due;

    idle();
    reset = 1'b1;
    step();
    step();
    sample();
    chk("rst_to_ws_valid", 64'(bus.ms_to_ws_valid), 64'd0);
    chk("rst_allowin", 64'(bus.ms_allowin), 64'd0);
    chk("rst_req_full", 64'(bus.ms_req_full), 64'd0);
    chk("rst_ld_wait", 64'(bus.ms_ld_wait), 64'd0);
    chk("rst_result", 64'(bus.ms_final_result), 64'd0);
    chk("rst_pc", 64'(bus.ms_pc), 64'd0);
    chk("rst_excp", 64'(bus.ms_excp), 64'd0);
    chk("rst_excp_num", 64'(bus.ms_excp_num), 64'd0);
    step();
    reset = 1'b0;
    sample();
    chk("post_rst_allowin", 64'(bus.ms_allowin), 64'd1);
    step();

    bus.es_excp     = 1'b1;
    bus.es_excp_num = 16'h00ab;
    issue(3'b000, 2'b00, 32'h1c00_0040, 32'hcafe_f00d);
    bus.es_excp     = 1'b0;
    bus.es_excp_num = 16'h0;
    sample();
    chk("alu_valid", 64'(bus.ms_to_ws_valid), 64'd1);
    chk("alu_result", 64'(bus.ms_final_result), 64'hcafe_f00d);
    chk("alu_dest", 64'(bus.ms_dest), 64'd16);
    chk("alu_excp", 64'(bus.ms_excp), 64'd1);
    chk("alu_excp_num", 64'(bus.ms_excp_num), 64'h00ab);
    step();

    issue(3'b101, 2'b00, 32'h1c00_0010, 32'h0);
    waits = 0;
    for (int k = 0; k < 3; k++) begin
      if (k == 2) begin
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = 32'h8765_4321;
      end
      sample();
      if (bus.ms_ld_wait) waits++;
      chk("ldw_not_valid", 64'(bus.ms_to_ws_valid), 64'd0);
      step();
    end
    bus.data_sram_data_ok = 1'b0;
    sample();
    chk("ldw_wait_cycles", 64'(waits), 64'd3);
    chk("ldw_valid", 64'(bus.ms_to_ws_valid), 64'd1);
    chk("ldw_result", 64'(bus.ms_final_result), 64'h8765_4321);
    chk("ldw_pc", 64'(bus.ms_pc), 64'h1c00_0010);
    chk("ldw_wait_done", 64'(bus.ms_ld_wait), 64'd0);
    step();
    sample();
    chk("ldw_gone", 64'(bus.ms_to_ws_valid), 64'd0);
    step();

    run_load("ldb", 3'b001, 2'd2, 32'h0080_0000, 32'hffff_ff80);
    run_load("ldbu", 3'b010, 2'd2, 32'h0080_0000, 32'h0000_0080);
    run_load("ldh", 3'b011, 2'd2, 32'h8001_0000, 32'hffff_8001);

    bus.ws_allowin = 1'b0;
    issue(3'b100, 2'd2, 32'h1c00_0020, 32'h0);
    respond(32'hbeef_1234);
    for (int k = 0; k < 4; k++) begin
      sample();
      chk("stall_valid", 64'(bus.ms_to_ws_valid), 64'd1);
      chk("stall_result", 64'(bus.ms_final_result), 64'h0000_beef);
      chk("stall_allowin", 64'(bus.ms_allowin), 64'd0);
      step();
    end
    bus.ws_allowin = 1'b1;
    sample();
    chk("stall_release_allowin", 64'(bus.ms_allowin), 64'd1);
    step();
    sample();
    chk("stall_handed_off", 64'(bus.ms_to_ws_valid), 64'd0);
    step();

    issue(3'b101, 2'd0, 32'h1c00_0030, 32'h0);
    bus.es_to_ms_valid = 1'b1;
    bus.es_ld_op       = 3'b101;
    bus.es_req_fire    = 1'b1;
    bus.es_req_sent    = 1'b1;
    sample();
    chk("two_held", 64'(bus.ms_allowin), 64'd0);
    step();
    bus.es_req_fire = 1'b0;
    bus.flush       = 1'b1;
    sample();
    chk("two_full", 64'(bus.ms_req_full), 64'd1);
    step();
    idle();
    sample();
    chk("flush_valid", 64'(bus.ms_to_ws_valid), 64'd0);
    chk("flush_wait", 64'(bus.ms_ld_wait), 64'd0);
    chk("flush_still_full", 64'(bus.ms_req_full), 64'd1);
    step();
    respond(32'h1111_1111);
    sample();
    chk("drop1_valid", 64'(bus.ms_to_ws_valid), 64'd0);
    chk("drop1_full", 64'(bus.ms_req_full), 64'd0);
    step();
    respond(32'h2222_2222);
    sample();
    chk("drop2_valid", 64'(bus.ms_to_ws_valid), 64'd0);
    step();
    run_load("post_flush", 3'b101, 2'd0, 32'h1234_5678, 32'h1234_5678);

    issue(3'b101, 2'd0, 32'h1c00_0050, 32'h0);
    bus.flush             = 1'b1;
    bus.data_sram_data_ok = 1'b1;
    bus.data_sram_rdata   = 32'h3333_3333;
    bus.es_to_ms_valid    = 1'b1;
    bus.es_req_fire       = 1'b1;
    step();
    idle();
    sample();
    chk("fsim_valid", 64'(bus.ms_to_ws_valid), 64'd0);
    chk("fsim_not_full", 64'(bus.ms_req_full), 64'd0);
    step();
    issue(3'b010, 2'd1, 32'h1c00_0060, 32'h0);
    sample();
    chk("fsim_full", 64'(bus.ms_req_full), 64'd1);
    chk("fsim_wait", 64'(bus.ms_ld_wait), 64'd1);
    step();
    respond(32'hdead_beef);
    sample();
    chk("fsim_stale_dropped", 64'(bus.ms_to_ws_valid), 64'd0);
    step();
    respond(32'h0000_ab00);
    sample();
    chk("fsim_valid2", 64'(bus.ms_to_ws_valid), 64'd1);
    chk("fsim_result", 64'(bus.ms_final_result), 64'h0000_00ab);
    step();

    issue(3'b101, 2'd0, 32'h1c00_0070, 32'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample();
    chk("wrst_valid", 64'(bus.ms_to_ws_valid), 64'd0);
    chk("wrst_wait", 64'(bus.ms_ld_wait), 64'd0);
    chk("wrst_full", 64'(bus.ms_req_full), 64'd0);
    chk("wrst_allowin", 64'(bus.ms_allowin), 64'd1);
    step();
    run_load("post_reset", 3'b001, 2'd1, 32'h0000_7f00, 32'h0000_007f);

    ex_pending = 1'b0;
    last_due   = 0;
    handoffs   = 0;
    ex_op      = 3'b000;
    ex_off     = 2'd0;
    ex_pc      = 32'h0;
    ex_res     = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      flushing = (c < 1200) && ($urandom_range(0, 29) == 0);
      if (!ex_pending && c < 1200 && $urandom_range(0, 2) != 0) begin
        ex_pending = 1'b1;
        ex_op      = 3'($urandom_range(0, 5));
        ex_pc      = $urandom & 32'hffff_fffc;
        ex_res     = $urandom;
        case (ex_op)
          3'b001, 3'b010: ex_off = 2'($urandom_range(0, 3));
          3'b011, 3'b100: ex_off = 2'($urandom_range(0, 1) * 2);
          default:        ex_off = 2'd0;
        endcase
      end
      ex_ld = ex_op != 3'b000;
      bus.flush          = flushing;
      bus.ws_allowin     = flushing ? 1'b0 : ($urandom_range(0, 3) != 0);
      bus.es_to_ms_valid = ex_pending && !(ex_ld && bus.ms_req_full);
      bus.es_ld_op       = ex_op;
      bus.es_addr_low    = ex_off;
      bus.es_pc          = ex_pc;
      bus.es_result      = ex_res;
      bus.es_dest        = ex_pc[6:2];
      bus.es_gr_we       = 1'b1;
      if (mem_due.size() > 0 && mem_due[0] <= c) begin
        bus.data_sram_data_ok = 1'b1;
        bus.data_sram_rdata   = mem_dat[0];
        void'(mem_due.pop_front());
        void'(mem_dat.pop_front());
      end else begin
        bus.data_sram_data_ok = 1'b0;
        bus.data_sram_rdata   = $urandom;
      end
      #1;
      take = bus.es_to_ms_valid && bus.ms_allowin && !flushing;
      bus.es_req_fire = take && ex_ld;
      bus.es_req_sent = take && ex_ld;
      sample();
      if (bus.ms_to_ws_valid && bus.ws_allowin) begin
        handoffs++;
        if (exp_q.size() == 0) begin
          chk("rnd_unexpected_handoff", 64'(exp_q.size()), 64'd1);
        end else begin
          e = exp_q.pop_front();
          chk("rnd_pc", 64'(bus.ms_pc), 64'(e.pc));
          chk("rnd_result", 64'(bus.ms_final_result), 64'(e.res));
          chk("rnd_dest", 64'(bus.ms_dest), 64'(e.dest));
        end
      end
      if (flushing) exp_q.delete();
      if (take) begin
        e.pc   = ex_pc;
        e.dest = ex_pc[6:2];
        e.res  = ex_res;
        if (ex_ld) begin
          d   = $urandom;
          due = c + $urandom_range(1, 4);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          mem_due.push_back(due);
          mem_dat.push_back(d);
          e.res = ref_ld(ex_op, int'(ex_off), d);
        end
        exp_q.push_back(e);
        ex_pending = 1'b0;
      end
      step();
    end
    idle();
    sample();
    chk("rnd_drained", 64'(exp_q.size()), 64'd0);
    chk("rnd_mem_drained", 64'(mem_due.size()), 64'd0);
    chk("rnd_activity", 64'(handoffs > 100), 64'd1);
    chk("rnd_end_full", 64'(bus.ms_req_full), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
